// File: rtl/ntt_loop_controller.sv
// Loop-index sequencer for one 128-point mixed-radix NTT pass: emits (p, k, j, i) tuples
// over a valid/ready handshake, with a programmable bubble between stages.
module ntt_loop_controller #(
  parameter int unsigned STAGE_GAP = 4,
  parameter int unsigned GAP_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [2:0] p,
  output logic [4:0] k,
  output logic [4:0] j,
  output logic [4:0] i,
  output logic [4:0] bf_cnt,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StRun, StGap, StDone} state_e;

  localparam logic [GAP_W-1:0] GapLast = GAP_W'(STAGE_GAP > 0 ? STAGE_GAP - 1 : 0);

  state_e           r_state;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_valid;
  logic [2:0]       r_p;
  logic [4:0]       r_k;
  logic [4:0]       r_j;
  logic [4:0]       r_i;
  logic [4:0]       r_bf;
  logic             r_busy;
  logic             r_done;

  logic [4:0] w_jmax;
  logic       w_fire;
  logic       w_last;

  // Inner-loop wrap point is 4^p - 1; the stage always ends on bf_cnt, so k needs no limit.
  always_comb begin
    w_jmax = 5'd15;
    case (r_p)
      3'd0:    w_jmax = 5'd0;
      3'd1:    w_jmax = 5'd3;
      default: w_jmax = 5'd15;
    endcase
  end

  assign w_fire = r_valid & out_ready;
  assign w_last = (r_bf == 5'd31);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_gap_cnt <= '0;
      r_valid   <= 1'b0;
      r_p       <= '0;
      r_k       <= '0;
      r_j       <= '0;
      r_i       <= '0;
      r_bf      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= StRun;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_p     <= '0;
            r_k     <= '0;
            r_j     <= '0;
            r_i     <= '0;
            r_bf    <= '0;
          end
        end
        StRun: begin
          if (w_fire) begin
            if (w_last) begin
              r_k  <= '0;
              r_j  <= '0;
              r_i  <= '0;
              r_bf <= '0;
              if (r_p == 3'd3) begin
                r_state <= StDone;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_p     <= '0;
              end else begin
                r_p <= r_p + 3'd1;
                if (STAGE_GAP != 0) begin
                  r_state   <= StGap;
                  r_valid   <= 1'b0;
                  r_gap_cnt <= '0;
                end
              end
            end else begin
              r_bf <= r_bf + 5'd1;
              if (r_p == 3'd3) begin
                r_i <= r_i + 5'd1;
              end else if (r_j == w_jmax) begin
                r_j <= '0;
                r_k <= r_k + 5'd1;
              end else begin
                r_j <= r_j + 5'd1;
              end
            end
          end
        end
        StGap: begin
          if (r_gap_cnt == GapLast) begin
            r_state <= StRun;
            r_valid <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign out_valid = r_valid;
  assign p         = r_p;
  assign k         = r_k;
  assign j         = r_j;
  assign i         = r_i;
  assign bf_cnt    = r_bf;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_ntt_loop_controller.sv
// Scoreboard bench for ntt_loop_controller: default-gap and zero-gap instances, checked
// against an independently generated nested-loop reference sequence.
module tb_ntt_loop_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_drv, sel, start, out_ready;
  logic rst0, rst1;
  assign rst0 = rst_drv | sel;
  assign rst1 = rst_drv | ~sel;

  logic       v0, v1, busy0, busy1, done0, done1;
  logic [2:0] p0, p1;
  logic [4:0] k0, k1, j0, j1, i0, i1, b0, b1;

  ntt_loop_controller #(.STAGE_GAP(4), .GAP_W(4)) u_dut_gap4 (
    .clk(clk), .rst(rst0), .start(start), .out_ready(out_ready), .out_valid(v0),
    .p(p0), .k(k0), .j(j0), .i(i0), .bf_cnt(b0), .busy(busy0), .done(done0)
  );

  ntt_loop_controller #(.STAGE_GAP(0), .GAP_W(4)) u_dut_gap0 (
    .clk(clk), .rst(rst1), .start(start), .out_ready(out_ready), .out_valid(v1),
    .p(p1), .k(k1), .j(j1), .i(i1), .bf_cnt(b1), .busy(busy1), .done(done1)
  );

  logic        m_valid, m_busy, m_done;
  logic [2:0]  m_p;
  logic [4:0]  m_k, m_j, m_i, m_b;
  logic [22:0] m_tup;
  assign m_valid = sel ? v1 : v0;
  assign m_busy  = sel ? busy1 : busy0;
  assign m_done  = sel ? done1 : done0;
  assign m_p     = sel ? p1 : p0;
  assign m_k     = sel ? k1 : k0;
  assign m_j     = sel ? j1 : j0;
  assign m_i     = sel ? i1 : i0;
  assign m_b     = sel ? b1 : b0;
  assign m_tup   = {m_p, m_k, m_j, m_i, m_b};

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [22:0] tup;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference sequence from plain nested loops; cyc is the beat's cycle when ready stays high.
  task automatic load_expect(input int gap);
    exp_t e;
    int   n;
    int   jn;
    int   kn;
    n = 0;
    sb.delete();
    for (int pp = 0; pp < 4; pp++) begin
      if (pp < 3) begin
        jn = 1 << (2 * pp);
        kn = 32 / jn;
        for (int kk = 0; kk < kn; kk++) begin
          for (int jj = 0; jj < jn; jj++) begin
            e.tup = {3'(pp), 5'(kk), 5'(jj), 5'd0, 5'(n % 32)};
            e.cyc = 1 + n + pp * gap;
            sb.push_back(e);
            n++;
          end
        end
      end else begin
        for (int ii = 0; ii < 32; ii++) begin
          e.tup = {3'd3, 5'd0, 5'd0, 5'(ii), 5'(ii)};
          e.cyc = 1 + n + pp * gap;
          sb.push_back(e);
          n++;
        end
      end
    end
  endtask

  // mode 0: ready high, 1: random ready, 2: 20-cycle stall on first p=3 beat
  task automatic run_pass(input int mode, input int gap, input int exp_done, input bit hold_start);
    exp_t        e;
    int          cyc;
    int          hs;
    int          stall;
    bit          prev_v;
    bit          prev_r;
    bit          finished;
    bit          stall_now;
    logic [22:0] prev_t;
    load_expect(gap);
    @(negedge clk);
    start     = 1'b1;
    out_ready = 1'b1;
    cyc = 0; hs = 0; stall = 0; prev_v = 1'b0; prev_r = 1'b0; finished = 1'b0;
    prev_t = '0;
    while (!finished && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (!hold_start) start = 1'b0;
      if (prev_v && !prev_r) begin
        check_val("hold_valid", 32'(m_valid), 32'd1);
        check_val("hold_tuple", 32'(m_tup), 32'(prev_t));
      end
      if (m_done) begin
        if (exp_done >= 0) check_val("done_cycle", cyc, exp_done);
        check_val("handshakes", hs, 128);
        check_val("sb_left", sb.size(), 0);
        check_val("done_busy", 32'(m_busy), 32'd0);
        check_val("done_valid", 32'(m_valid), 32'd0);
        finished  = 1'b1;
        out_ready = 1'b1;
      end else begin
        check_val("busy", 32'(m_busy), 32'd1);
        stall_now = (mode == 2) && m_valid && (m_p == 3'd3) && (m_i == 5'd0) && (stall < 20);
        case (mode)
          1:       out_ready = 1'($urandom_range(0, 1));
          2:       out_ready = !stall_now;
          default: out_ready = 1'b1;
        endcase
        if (stall_now) stall++;
        if (m_valid && out_ready) begin
          hs++;
          if (sb.size() == 0) begin
            check_val("extra_beat", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            check_val("tuple", 32'(m_tup), 32'(e.tup));
            if (mode == 0) check_val("beat_cycle", cyc, e.cyc);
          end
        end
      end
      prev_v = m_valid;
      prev_r = out_ready;
      prev_t = m_tup;
    end
    if (!finished) check_val("done_timeout", 32'(finished), 32'd1);
    @(negedge clk);
    check_val("idle_valid", 32'(m_valid), 32'd0);
    check_val("idle_busy", 32'(m_busy), 32'd0);
    check_val("idle_done", 32'(m_done), 32'd0);
    if (hold_start) begin
      @(negedge clk);
      check_val("restart_valid", 32'(m_valid), 32'd1);
      check_val("restart_tuple", 32'(m_tup), 32'd0);
      start   = 1'b0;
      rst_drv = 1'b1;
      @(negedge clk);
      rst_drv = 1'b0;
    end
  endtask

  task automatic reset_mid_pass();
    int cyc;
    @(negedge clk);
    start     = 1'b1;
    out_ready = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end while (!(m_valid && m_p == 3'd2 && m_b == 5'd10) && cyc < 500);
    check_val("reach_p2_beat10", 32'(m_tup), {9'd0, 3'd2, 5'd0, 5'd10, 5'd0, 5'd10});
    rst_drv = 1'b1;
    @(negedge clk);
    rst_drv = 1'b0;
    check_val("rst_tuple", 32'(m_tup), 32'd0);
    check_val("rst_valid", 32'(m_valid), 32'd0);
    check_val("rst_busy", 32'(m_busy), 32'd0);
    check_val("rst_done", 32'(m_done), 32'd0);
    @(negedge clk);
    check_val("rst_stays_idle", 32'(m_valid), 32'd0);
  endtask

  initial begin
    rst_drv   = 1'b1;
    sel       = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_tuple", 32'(m_tup), 32'd0);
    check_val("reset_valid", 32'(m_valid), 32'd0);
    check_val("reset_busy", 32'(m_busy), 32'd0);
    check_val("reset_done", 32'(m_done), 32'd0);
    rst_drv = 1'b0;
    @(negedge clk);
    check_val("idle_no_start", 32'(m_valid), 32'd0);

    run_pass(0, 4, 141, 1'b0);
    run_pass(1, 4, -1, 1'b0);
    run_pass(2, 4, 161, 1'b0);
    reset_mid_pass();
    run_pass(0, 4, 141, 1'b0);
    run_pass(0, 4, 141, 1'b1);

    @(negedge clk);
    sel = 1'b1;
    @(negedge clk);
    run_pass(0, 0, 129, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
